// File: rtl/y_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry held in a register.
// Reports carry-out and signed overflow with a one-cycle done pulse.
module y_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t r_state;
  state_t w_state_n;

  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_acc;
  logic                   r_c;
  logic [CW-1:0]          r_cnt;
  logic [CHUNK:0]         w_sum;
  logic                   w_cin_msb;
  logic [WIDTH+CHUNK-1:0] w_shift;
  logic                   w_accept;
  logic                   w_last;

  assign w_sum = {1'b0, r_a[CHUNK-1:0]}
               + {1'b0, r_b[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_c};

  // Sum bit = a ^ b ^ cin, so the carry into the chunk MSB falls out directly.
  assign w_cin_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];

  assign w_shift = {w_sum[CHUNK-1:0], r_acc} >> CHUNK;

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept  = 1'b1;
          w_state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == CW'(NCHUNK - 1)) begin
          w_last    = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= w_last;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= sub ? ~b : b;
        r_c   <= sub;
        r_cnt <= '0;
      end else if (busy) begin
        r_a   <= r_a >> CHUNK;
        r_b   <= r_b >> CHUNK;
        r_acc <= w_shift[WIDTH-1:0];
        r_c   <= w_sum[CHUNK];
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last) begin
        z    <= w_shift[WIDTH-1:0];
        cout <= w_sum[CHUNK];
        ovf  <= w_cin_msb ^ w_sum[CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_y_chunk_adder.sv
// Bench for y_chunk_adder: directed handshake/reset cases plus a random
// sweep over several WIDTH/CHUNK pairs against an arithmetic model.
module tb_y_chunk_adder;
  localparam int NI = 5;

  function automatic int gw(int g);
    case (g)
      0: return 32;
      1: return 8;
      2: return 8;
      3: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int gc(int g);
    case (g)
      0: return 8;
      1: return 8;
      2: return 1;
      3: return 4;
      default: return 32;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st [NI];
  logic        sb [NI];
  logic [31:0] ta [NI];
  logic [31:0] tbv[NI];
  logic        bu [NI];
  logic        dn [NI];
  logic [31:0] tz [NI];
  logic        co [NI];
  logic        ov [NI];

  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GW = gw(g);
    localparam int GC = gc(g);
    logic [GW-1:0] w_z;
    y_chunk_adder #(.WIDTH(GW), .CHUNK(GC)) u_dut (
      .clk  (clk),
      .reset(reset),
      .start(st[g]),
      .sub  (sb[g]),
      .a    (ta[g][GW-1:0]),
      .b    (tbv[g][GW-1:0]),
      .busy (bu[g]),
      .done (dn[g]),
      .z    (w_z),
      .cout (co[g]),
      .ovf  (ov[g])
    );
    assign tz[g] = 32'(w_z);
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result as modular arithmetic; overflow by operand/result sign rule.
  task automatic model(input int w, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic c,
                       output logic o);
    longint unsigned mask, aa, bb, full;
    logic sa, sbb, sz;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b} & mask;
    if (s) full = aa + ((~bb) & mask) + 64'd1;
    else   full = aa + bb;
    z   = 32'(full & mask);
    c   = full[w];
    sa  = a[w-1];
    sbb = b[w-1];
    sz  = z[w-1];
    if (s) o = (sa != sbb) && (sz != sa);
    else   o = (sa == sbb) && (sz != sa);
  endtask

  // Called #1 after a rising edge; starts at the next edge.
  task automatic run_op(int g, logic s, logic [31:0] a, logic [31:0] b);
    int n, lat;
    bit busy_ok;
    logic [31:0] ez;
    logic ec, eo;
    n = gw(g) / gc(g);
    model(gw(g), s, a, b, ez, ec, eo);
    st[g] = 1'b1;
    sb[g] = s;
    ta[g] = a;
    tbv[g] = b;
    @(posedge clk);
    #1;
    st[g] = 1'b0;
    sb[g] = ~s;
    ta[g] = $urandom;
    tbv[g] = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!dn[g] && lat < n + 3) begin
      if (!bu[g]) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("lat[%0d]", g), 64'(lat), 64'(n));
    check($sformatf("busy_run[%0d]", g), {63'd0, busy_ok}, 64'd1);
    check($sformatf("busy_done[%0d]", g), {63'd0, bu[g]}, 64'd0);
    check($sformatf("z[%0d]", g), {32'd0, tz[g]}, {32'd0, ez});
    check($sformatf("cout[%0d]", g), {63'd0, co[g]}, {63'd0, ec});
    check($sformatf("ovf[%0d]", g), {63'd0, ov[g]}, {63'd0, eo});
  endtask

  function automatic logic [31:0] rnd(int w);
    logic [31:0] m, msb;
    int r;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb = 32'd1 << (w - 1);
    r = $urandom_range(9, 0);
    case (r)
      0: return 32'd0;
      1: return m;
      2: return msb;
      3: return msb - 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    int cnt;
    logic [31:0] zs;
    for (int g = 0; g < NI; g++) begin
      st[g] = 1'b0;
      sb[g] = 1'b0;
      ta[g] = '0;
      tbv[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_z[%0d]", g), {32'd0, tz[g]}, 64'd0);
      check($sformatf("rst_flags[%0d]", g),
            {60'd0, bu[g], dn[g], co[g], ov[g]}, 64'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
    check("wrap_z", {32'd0, tz[0]}, 64'h0);
    check("wrap_c", {63'd0, co[0]}, 64'd1);
    @(posedge clk);
    #1;
    check("done_fall", {63'd0, dn[0]}, 64'd0);

    run_op(0, 1'b1, 32'd5, 32'd7);
    check("sub57_z", {32'd0, tz[0]}, 64'hFFFF_FFFE);
    // Issued in the done cycle of the previous op: back-to-back.
    run_op(0, 1'b1, 32'd7, 32'd5);
    check("sub75_z", {32'd0, tz[0]}, 64'h2);
    check("sub75_c", {63'd0, co[0]}, 64'd1);
    run_op(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    check("ovf_add", {62'd0, ov[0], co[0]}, 64'b10);
    run_op(0, 1'b1, 32'h8000_0000, 32'd1);
    check("ovf_sub_z", {32'd0, tz[0]}, 64'h7FFF_FFFF);
    check("ovf_sub", {62'd0, ov[0], co[0]}, 64'b11);

    st[0] = 1'b1;
    sb[0] = 1'b0;
    ta[0] = 32'h0000_1000;
    tbv[0] = 32'h0000_0234;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    #1;
    st[0] = 1'b1;
    ta[0] = 32'hDEAD_BEEF;
    tbv[0] = 32'h1111_1111;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    cnt = 0;
    zs = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (dn[0]) begin
        cnt++;
        zs = tz[0];
      end
    end
    check("ign_done_cnt", 64'(cnt), 64'd1);
    check("ign_z", {32'd0, zs}, 64'h0000_1234);

    st[0] = 1'b1;
    ta[0] = 32'hAAAA_AAAA;
    tbv[0] = 32'h1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_z", {32'd0, tz[0]}, 64'd0);
    check("mid_rst_flags",
          {60'd0, bu[0], dn[0], co[0], ov[0]}, 64'd0);
    cnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (dn[0]) cnt++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (dn[0] || bu[0]) cnt++;
    end
    check("mid_rst_nodone", 64'(cnt), 64'd0);
    run_op(0, 1'b0, 32'h1234_5678, 32'h1111_1111);
    check("post_rst_z", {32'd0, tz[0]}, 64'h2345_6789);

    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(g, 1'($urandom_range(1, 0)), rnd(gw(g)), rnd(gw(g)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
